// File: rtl/sync_pkt_fifo_if.sv
// Handshake and status bundle for sync_pkt_fifo.
// Widths follow the rounded-up depth of the FIFO.
interface sync_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_drop;
  logic                  wr_full;
  logic                  wr_afull;
  logic [PW:0]           wr_cnt;
  logic                  overflow;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  rd_aempty;
  logic [PW:0]           rd_cnt;

  modport master (
    output wr_en, wr_data, wr_last, wr_drop, rd_en,
    input  wr_full, wr_afull, wr_cnt, overflow,
    input  rd_data, rd_empty, rd_aempty, rd_cnt
  );

  modport slave (
    input  wr_en, wr_data, wr_last, wr_drop, rd_en,
    output wr_full, wr_afull, wr_cnt, overflow,
    output rd_data, rd_empty, rd_aempty, rd_cnt
  );
endinterface

// File: rtl/sync_pkt_fifo.sv
// Single-clock packet FIFO: beats become readable on commit of the
// last beat; partial or overflowed packets roll back to the commit point.
module sync_pkt_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter bit DATA_FLOAT_OUT = 1'b0,
  parameter int AFULL_TH       = (2 ** $clog2(FIFO_DEPTH)) - 2,
  parameter int AEMPTY_TH      = 2
) (
  input logic            clk,
  input logic            rst,
  sync_pkt_fifo_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int REAL_DEPTH = 2 ** PW;
  localparam logic [31:0] AF_TH = 32'(AFULL_TH);
  localparam logic [31:0] AE_TH = 32'(AEMPTY_TH);

  typedef logic [PW:0] ptr_t;

  ptr_t wptr;
  ptr_t cptr;
  ptr_t rptr;
  ptr_t wr_cnt;
  ptr_t rd_cnt;

  logic pkt_err;
  logic ovf;
  logic full;
  logic empty;
  logic avail;
  logic wr_acc;
  logic wr_bad;
  logic mem_rd;

  logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];
  logic [DATA_WIDTH-1:0] dout;

  assign wr_cnt = wptr - rptr;
  assign full   = (wr_cnt == ptr_t'(REAL_DEPTH));
  assign avail  = (cptr != rptr);

  // a refused beat is one hitting full or arriving after an overflow
  assign wr_bad = bus.wr_en & ~bus.wr_drop & (full | pkt_err);
  assign wr_acc = bus.wr_en & ~bus.wr_drop & ~full & ~pkt_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      cptr    <= '0;
      pkt_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf <= bus.wr_en & full & ~bus.wr_drop;
      if (bus.wr_drop) begin
        wptr    <= cptr;
        pkt_err <= 1'b0;
      end else if (wr_bad) begin
        if (bus.wr_last) begin
          wptr    <= cptr;
          pkt_err <= 1'b0;
        end else begin
          pkt_err <= 1'b1;
        end
      end else if (wr_acc) begin
        wptr <= wptr + ptr_t'(1);
        if (bus.wr_last) begin
          cptr <= wptr + ptr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[PW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
    end else if (mem_rd) begin
      rptr <= rptr + ptr_t'(1);
    end
  end

  if (DATA_FLOAT_OUT) begin : g_fwft
    logic fv;
    logic pop;

    assign pop    = bus.rd_en & fv;
    // refill the head register when it is empty or leaving this cycle
    assign mem_rd = avail & (~fv | pop);
    assign empty  = ~fv;
    assign rd_cnt = cptr - rptr + ptr_t'(fv);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fv   <= 1'b0;
        dout <= '0;
      end else if (mem_rd) begin
        fv   <= 1'b1;
        dout <= mem[rptr[PW-1:0]];
      end else if (pop) begin
        fv <= 1'b0;
      end
    end
  end else begin : g_std
    assign mem_rd = bus.rd_en & avail;
    assign empty  = ~avail;
    assign rd_cnt = cptr - rptr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout <= '0;
      end else if (mem_rd) begin
        dout <= mem[rptr[PW-1:0]];
      end
    end
  end

  assign bus.wr_full   = full;
  assign bus.wr_afull  = (32'(wr_cnt) >= AF_TH);
  assign bus.wr_cnt    = wr_cnt;
  assign bus.overflow  = ovf;
  assign bus.rd_data   = dout;
  assign bus.rd_empty  = empty;
  assign bus.rd_aempty = (32'(rd_cnt) <= AE_TH);
  assign bus.rd_cnt    = rd_cnt;
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Scoreboard bench for sync_pkt_fifo in standard and FWFT modes,
// checked against a packet-level queue model.
module tb_sync_pkt_fifo;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_pkt_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bs ();
  sync_pkt_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bf ();

  sync_pkt_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .DATA_FLOAT_OUT(1'b0),
    .AFULL_TH(14), .AEMPTY_TH(2)
  ) u_std (.clk(clk), .rst(rst), .bus(bs));

  sync_pkt_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .DATA_FLOAT_OUT(1'b1),
    .AFULL_TH(14), .AEMPTY_TH(2)
  ) u_fwft (.clk(clk), .rst(rst), .bus(bf));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb_s[$];
  logic [7:0] sb_f[$];
  logic [7:0] pq_s[$];
  logic [7:0] pq_f[$];
  int cq_n = 0;
  bit err_m = 1'b0;
  bit ovf_m = 1'b0;
  bit fs = 1'b0;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rst();
    chk("rst_s_wr_cnt", int'(bs.wr_cnt), 0);
    chk("rst_s_rd_cnt", int'(bs.rd_cnt), 0);
    chk("rst_s_full", int'(bs.wr_full), 0);
    chk("rst_s_afull", int'(bs.wr_afull), 0);
    chk("rst_s_ovf", int'(bs.overflow), 0);
    chk("rst_s_empty", int'(bs.rd_empty), 1);
    chk("rst_s_aempty", int'(bs.rd_aempty), 1);
    chk("rst_s_rd_data", int'(bs.rd_data), 0);
    chk("rst_f_wr_cnt", int'(bf.wr_cnt), 0);
    chk("rst_f_rd_cnt", int'(bf.rd_cnt), 0);
    chk("rst_f_empty", int'(bf.rd_empty), 1);
    chk("rst_f_rd_data", int'(bf.rd_data), 0);
  endtask

  task automatic idle_inputs();
    bs.wr_en = 0; bs.wr_data = '0; bs.wr_last = 0;
    bs.wr_drop = 0; bs.rd_en = 0;
    bf.wr_en = 0; bf.wr_data = '0; bf.wr_last = 0;
    bf.wr_drop = 0; bf.rd_en = 0;
  endtask

  task automatic step_s(bit en, logic [7:0] d, bit last,
                        bit drop, bit rd);
    int occ;
    @(negedge clk);
    occ = cq_n + pq_s.size();
    chk("std_wr_cnt", int'(bs.wr_cnt), occ);
    chk("std_rd_cnt", int'(bs.rd_cnt), cq_n);
    chk("std_full", int'(bs.wr_full), int'(occ == 16));
    chk("std_afull", int'(bs.wr_afull), int'(occ >= 14));
    chk("std_empty", int'(bs.rd_empty), int'(cq_n == 0));
    chk("std_aempty", int'(bs.rd_aempty), int'(cq_n <= 2));
    chk("std_overflow", int'(bs.overflow), int'(ovf_m));
    bs.wr_en = en; bs.wr_data = d; bs.wr_last = last;
    bs.wr_drop = drop; bs.rd_en = rd;
    ovf_m = en && (occ == 16) && !drop;
    if (rd && cq_n > 0) cq_n--;
    if (drop) begin
      pq_s.delete();
      err_m = 0;
    end else if (en && (occ == 16 || err_m)) begin
      if (last) begin
        pq_s.delete();
        err_m = 0;
      end else begin
        err_m = 1;
      end
    end else if (en) begin
      pq_s.push_back(d);
      if (last) begin
        foreach (pq_s[i]) sb_s.push_back(pq_s[i]);
        cq_n += pq_s.size();
        pq_s.delete();
      end
    end
  endtask

  task automatic step_f(bit en, logic [7:0] d, bit last,
                        bit drop, bit rd);
    @(negedge clk);
    bf.wr_en = en; bf.wr_data = d; bf.wr_last = last;
    bf.wr_drop = drop; bf.rd_en = rd;
    if (drop) begin
      pq_f.delete();
    end else if (en) begin
      pq_f.push_back(d);
      if (last) begin
        foreach (pq_f[i]) sb_f.push_back(pq_f[i]);
        pq_f.delete();
      end
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    idle_inputs();
    #3 rst = 1'b1;
    #1 chk_rst();
    pq_s.delete(); sb_s.delete(); cq_n = 0;
    err_m = 0; ovf_m = 0;
    pq_f.delete(); sb_f.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // standard mode: data shows up one cycle after an accepted read
  initial begin
    forever begin
      @(negedge clk);
      if (fs) begin
        if (sb_s.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL std_rd_extra: got %0h expected none", bs.rd_data);
        end else begin
          chk("std_rd_data", int'(bs.rd_data), int'(sb_s.pop_front()));
        end
      end
      #2 fs = bs.rd_en & ~bs.rd_empty & !rst;
    end
  end

  // FWFT mode: head beat is on rd_data when it is popped
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bf.rd_en && !bf.rd_empty && !rst) begin
        if (sb_f.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL fwft_rd_extra: got %0h expected none", bf.rd_data);
        end else begin
          chk("fwft_rd_data", int'(bf.rd_data), int'(sb_f.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_rst();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step_s(1, 8'hA0 + 8'(i), i == 3, 0, 0);
    repeat (2) step_s(0, 0, 0, 0, 0);
    repeat (4) step_s(0, 0, 0, 0, 1);
    repeat (2) step_s(0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step_s(1, 8'hB0 + 8'(i), 0, 0, 0);
    step_s(0, 0, 0, 1, 0);
    step_s(1, 8'h55, 1, 0, 0);
    step_s(0, 0, 0, 0, 0);
    step_s(0, 0, 0, 0, 1);
    repeat (2) step_s(0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) step_s(1, 8'hC0 + 8'(i), 0, 0, 0);
    step_s(1, 8'hEE, 0, 0, 0);
    step_s(1, 8'hEF, 1, 0, 0);
    repeat (2) step_s(0, 0, 0, 0, 0);
    step_s(0, 0, 0, 0, 1);
    step_s(0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) step_s(1, 8'($urandom), 1, 0, 1);
    repeat (4) step_s(0, 0, 0, 0, 1);
    step_s(0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      step_s($urandom_range(0, 3) != 0, 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             i < 250 ? $urandom_range(0, 2) == 0
                     : $urandom_range(0, 2) != 0);
    end
    repeat (40) step_s(0, 0, 0, 0, 1);
    step_s(0, 0, 0, 1, 0);
    repeat (2) step_s(0, 0, 0, 0, 0);
    chk("std_leftover", sb_s.size(), 0);

    for (int i = 0; i < 3; i++) step_s(1, 8'h11 + 8'(i), i == 2, 0, 0);
    step_s(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step_s(1, 8'h21 + 8'(i), 0, 0, 0);
    reset_mid();
    repeat (2) step_s(0, 0, 0, 0, 0);
    step_s(1, 8'h99, 1, 0, 0);
    step_s(0, 0, 0, 0, 1);
    repeat (2) step_s(0, 0, 0, 0, 0);
    chk("std_leftover_rst", sb_s.size(), 0);

    step_f(1, 8'h7E, 1, 0, 0);
    step_f(0, 0, 0, 0, 0);
    chk("fwft_empty_e1", int'(bf.rd_empty), 1);
    step_f(0, 0, 0, 0, 0);
    chk("fwft_empty_e2", int'(bf.rd_empty), 0);
    chk("fwft_head", int'(bf.rd_data), 8'h7E);
    step_f(0, 0, 0, 0, 1);
    step_f(0, 0, 0, 0, 0);
    chk("fwft_empty_pop", int'(bf.rd_empty), 1);

    for (int r = 0; r < 6; r++) begin
      int beats = 0;
      while (beats < 10) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          step_f(1, 8'($urandom), b == len - 1, 0,
                 $urandom_range(0, 1) == 1);
          beats++;
        end
        if ($urandom_range(0, 5) == 0) begin
          step_f(1, 8'($urandom), 0, 0, 0);
          step_f(0, 0, 0, 1, 0);
          beats++;
        end
      end
      repeat (20) step_f(0, 0, 0, 0, 1);
    end
    repeat (2) step_f(0, 0, 0, 0, 0);
    chk("fwft_empty_end", int'(bf.rd_empty), 1);
    chk("fwft_leftover", sb_f.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
